// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// equal ripple segments with a register stage after each; valid/ready on both sides.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic              adv;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [STAGES-1:0] cin;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  b_d  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [SEG:0]      seg  [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv = !vld_q[LAST] || out_ready;

  always_comb begin
    vld_d = '0;
    cy_d  = '0;
    cin   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_d[k]  = '0;
      b_d[k]  = '0;
      s_d[k]  = '0;
      s_in[k] = '0;
      seg[k]  = '0;
    end

    vld_d[0] = in_valid;
    a_d[0]   = A;
    b_d[0]   = SUB ? ~B : B;
    cin[0]   = SUB;
    for (int unsigned k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      cin[k]   = cy_q[k-1];
      s_in[k]  = s_q[k-1];
    end

    // Stage k completes bits [k*SEG +: SEG] on top of the partial sum it inherits.
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg[k] = {1'b0, a_d[k][k*SEG +: SEG]} + {1'b0, b_d[k][k*SEG +: SEG]}
             + {{SEG{1'b0}}, cin[k]};
      s_d[k] = s_in[k];
      s_d[k][k*SEG +: SEG] = seg[k][SEG-1:0];
      cy_d[k] = seg[k][SEG];
    end

    ovf_d  = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
             (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    zero_d = (s_d[LAST] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign SUM       = s_q[LAST];
  assign C_OUT     = cy_q[LAST];
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vectors, stall/bubble/reset
// sequences, and randomized traffic against an arithmetic scoreboard.
module tb_pipelined_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, c_out, ovf, zero;
  logic [7:0] sum;

  logic       iv4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, c4, ovf4, z4;
  logic [3:0] sum4;

  int n_chk = 0;
  int n_pass = 0;
  logic [10:0] sbq[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready),
    .SUM(sum), .C_OUT(c_out), .OVF(ovf), .ZERO(zero)
  );

  pipelined_addsub #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .A(a4), .B(b4), .SUB(sub4), .out_valid(ov4), .out_ready(1'b1),
    .SUM(sum4), .C_OUT(c4), .OVF(ovf4), .ZERO(z4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on the operands, returns {sum, c, ovf, zero}.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int ua, ub, sa, sb, r, sr;
    logic c;
    logic [7:0] res;
    ua = int'(x); ub = int'(y);
    sa = int'($signed(x)); sb = int'($signed(y));
    if (s) begin r = ua - ub; sr = sa - sb; c = (ua >= ub); end
    else   begin r = ua + ub; sr = sa + sb; c = (r > 255);  end
    res = 8'(r & 255);
    return {res, c, (sr > 127) || (sr < -128), res == 8'd0};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
        else chk("sb_result", {21'd0, sum, c_out, ovf, zero}, {21'd0, sbq.pop_front()});
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b, sub));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] sum;
    logic       c, o, z;
  } vec_t;

  vec_t vecs[7];

  task automatic apply_vec(input vec_t v);
    in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub; out_ready = 1'b1;
    @(negedge clk);
    chk("vec_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("vec_early", out_valid, 0);
    step();
    @(negedge clk);
    chk("vec_valid", out_valid, 1);
    chk("vec_sum", sum, v.sum);
    chk("vec_flags", {c_out, ovf, zero}, {v.c, v.o, v.z});
    step();
  endtask

  initial begin
    int idx, k;
    logic exp_ov[6];
    logic pat[6];

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {c_out, ovf, zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst4_outs", {ov4, sum4, c4, ovf4, z4}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back stream with a three-cycle output stall
    idx = 0; k = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 6) begin in_valid = 1'b1; a = 8'(idx); b = 8'(idx + 1); sub = 1'b0; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
      end
      if (out_valid) chk("stream_sum", sum, 32'(2 * k + 1));
      if (out_valid && out_ready) k++;
      if (in_valid && in_ready) idx++;
      step();
    end
    chk("stream_count", k, 6);
    out_ready = 1'b1;

    // Bubble propagation
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_ov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      in_valid = pat[c]; a = 8'(c + 10); b = 8'd3; sub = 1'b0;
      @(negedge clk);
      chk("bubble_out_valid", out_valid, 32'(exp_ov[c]));
      step();
    end

    // Asynchronous reset with two operations in flight
    in_valid = 1'b1; a = 8'd1; b = 8'd2; sub = 1'b0;
    step();
    a = 8'd3; b = 8'd4;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_flags", {c_out, ovf, zero}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
      step();
    end
    apply_vec(vecs[0]);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", sbq.size(), 0);

    // Single-stage 4-bit instance
    iv4 = 1'b1; a4 = 4'h9; b4 = 4'h8; sub4 = 1'b0;
    @(negedge clk);
    chk("w4_in_ready", ir4, 1);
    step();
    a4 = 4'h7; b4 = 4'h1;
    @(negedge clk);
    chk("w4_a_valid", ov4, 1);
    chk("w4_a", {sum4, c4, ovf4, z4}, {4'h1, 1'b1, 1'b1, 1'b0});
    step();
    a4 = 4'h3; b4 = 4'h3; sub4 = 1'b1;
    @(negedge clk);
    chk("w4_b", {sum4, c4, ovf4, z4}, {4'h8, 1'b0, 1'b1, 1'b0});
    step();
    iv4 = 1'b0;
    @(negedge clk);
    chk("w4_c", {sum4, c4, ovf4, z4}, {4'h0, 1'b1, 1'b0, 1'b1});
    step();
    @(negedge clk);
    chk("w4_idle", ov4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
